// File: rtl/uart_program_loader_if.sv
// Byte stream from the UART receiver and the word write port into instruction memory.
// The loader uses the master view; the UART/memory side uses the slave view.
interface uart_program_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  rx_valid,
    input  rx_byte,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_byte,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/uart_program_loader.sv
// UART boot loader: length header, word assembly, checksum and idle timeout.
// The CPU is held while a load runs, and also afterwards if the load failed.
module uart_program_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter bit LITTLE_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash,
  uart_program_loader_if.master bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0]     LAST_BYTE = BW'(BPW - 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       CAPACITY  = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WC_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  state_t                state_r;
  logic                  flash_q_r;
  logic [7:0]            len_lo_r;
  logic [15:0]           n_len_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic [BW-1:0]         byte_cnt_r;
  logic [7:0]            csum_r;
  logic [TW-1:0]         tmo_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  cpu_hold_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic [ADDR_WIDTH:0]   word_count_r;
  logic [DATA_WIDTH-1:0] word_next_s;
  logic [15:0]           n_len_s;

  // Shift one byte into the word; little-endian fills from the bottom byte upwards.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [7:0] b);
    if (LITTLE_ENDIAN) begin
      shift_in = (w >> 8) | (DATA_WIDTH'(b) << (DATA_WIDTH - 8));
    end else begin
      shift_in = (w << 8) | DATA_WIDTH'(b);
    end
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    csum_add = sum + b;
  endfunction

  // Word including the byte currently on the bus, and the full header count.
  always_comb begin
    word_next_s = shift_in(word_r, bus.rx_byte);
    n_len_s     = {bus.rx_byte, len_lo_r};
  end

  // Loader state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      flash_q_r    <= 1'b0;
      len_lo_r     <= 8'd0;
      n_len_r      <= 16'd0;
      word_r       <= '0;
      byte_cnt_r   <= '0;
      csum_r       <= 8'd0;
      tmo_r        <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      cpu_hold_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      word_count_r <= '0;
    end else begin
      flash_q_r <= flash;
      mem_we_r  <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flash && !flash_q_r) begin
            state_r      <= LEN_LO;
            busy_r       <= 1'b1;
            cpu_hold_r   <= 1'b1;
            error_r      <= 1'b0;
            word_count_r <= '0;
            csum_r       <= 8'd0;
            byte_cnt_r   <= '0;
            tmo_r        <= '0;
            word_r       <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        LEN_LO, LEN_HI, PAYLOAD, CHECK: begin
          if (bus.rx_valid) begin
            tmo_r <= '0;
            case (state_r)
              LEN_LO: begin
                len_lo_r <= bus.rx_byte;
                state_r  <= LEN_HI;
              end
              LEN_HI: begin
                n_len_r <= n_len_s;
                if (32'(n_len_s) > CAPACITY) begin
                  state_r <= ERROR;
                  error_r <= 1'b1;
                end else if (n_len_s == 16'd0) begin
                  state_r <= CHECK;
                end else begin
                  state_r <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                csum_r <= csum_add(csum_r, bus.rx_byte);
                word_r <= word_next_s;
                if (byte_cnt_r == LAST_BYTE) begin
                  // Word complete: the write goes out next cycle at the pre-increment address.
                  byte_cnt_r   <= '0;
                  mem_we_r     <= 1'b1;
                  mem_addr_r   <= word_count_r[ADDR_WIDTH-1:0];
                  mem_wdata_r  <= word_next_s;
                  word_count_r <= word_count_r + WC_ONE;
                  if (32'(word_count_r) + 32'd1 == 32'(n_len_r)) begin
                    state_r <= CHECK;
                  end else begin
                    state_r <= PAYLOAD;
                  end
                end else begin
                  byte_cnt_r <= byte_cnt_r + BW'(1);
                end
              end
              default: begin
                if (bus.rx_byte == csum_r) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= ERROR;
                  error_r <= 1'b1;
                end
              end
            endcase
          end else if (tmo_r == TMO_LAST) begin
            state_r <= ERROR;
            error_r <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        DONE: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          cpu_hold_r <= 1'b0;
        end
        ERROR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          // An illegal encoding is treated as a failed load so the CPU stays held.
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          error_r    <= 1'b1;
          cpu_hold_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign word_count    = word_count_r;
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: a 32-bit little-endian and a 16-bit big-endian instance,
// directed and random loads compared against a byte-stream reference model.
module tb_uart_program_loader;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flash_v = 1'b0;
  logic       rx_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       flash_a, flash_b;
  logic       hold_a, busy_a, done_a, err_a;
  logic       hold_b, busy_b, done_b, err_b;
  logic [10:0] wc_a, wc_b;
  logic       busy_s, hold_s, done_s, err_s;
  logic [10:0] wc_s;

  uart_program_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if_a ();
  uart_program_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) if_b ();

  uart_program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .rst(rst), .flash(flash_a), .bus(if_a), .cpu_hold(hold_a), .busy(busy_a),
    .done(done_a), .error(err_a), .word_count(wc_a));

  uart_program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LITTLE_ENDIAN(1'b0), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .rst(rst), .flash(flash_b), .bus(if_b), .cpu_hold(hold_b), .busy(busy_b),
    .done(done_b), .error(err_b), .word_count(wc_b));

  assign flash_a       = flash_v & ~sel;
  assign flash_b       = flash_v & sel;
  assign if_a.rx_valid = rx_valid & ~sel;
  assign if_b.rx_valid = rx_valid & sel;
  assign if_a.rx_byte  = rx_byte;
  assign if_b.rx_byte  = rx_byte;
  assign busy_s = sel ? busy_b : busy_a;
  assign hold_s = sel ? hold_b : hold_a;
  assign done_s = sel ? done_b : done_a;
  assign err_s  = sel ? err_b  : err_a;
  assign wc_s   = sel ? wc_b   : wc_a;

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [63:0] data; } wr_t;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream_q[$];
  bit         exp_done, exp_err;
  int         exp_wc;
  int         done_cnt;
  bit         hold_at_done, hold_after_done, hold_dropped, done_prev;
  int         check_count = 0;
  int         error_count = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory writes and done/hold behaviour observed on the falling edge.
  always @(negedge clk) begin
    if (if_a.mem_we) got_q.push_back({16'(if_a.mem_addr), 64'(if_a.mem_wdata)});
    if (if_b.mem_we) got_q.push_back({16'(if_b.mem_addr), 64'(if_b.mem_wdata)});
    if (done_prev) hold_after_done = hold_s;
    if (done_s) begin
      done_cnt++;
      hold_at_done = hold_s;
    end
    if (busy_s && !hold_s) hold_dropped = 1'b1;
    done_prev = done_s;
  end

  // Reference model: interpret the byte stream (header, payload, checksum) directly.
  function automatic void build_expect(input int bpw, input bit le);
    int n;
    int sum;
    exp_q.delete();
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    if (n > 1024) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_wc = 0;
      return;
    end
    sum = 0;
    for (int w = 0; w < n; w++) begin
      logic [63:0] d;
      d = 64'd0;
      for (int k = 0; k < bpw; k++) begin
        int b;
        b = int'(stream_q[2 + w * bpw + k]);
        sum += b;
        if (le) d = d | (64'(b) << (8 * k));
        else    d = d | (64'(b) << (8 * (bpw - 1 - k)));
      end
      exp_q.push_back({16'(w), d});
    end
    exp_wc   = n;
    exp_done = (int'(stream_q[2 + n * bpw]) == (sum % 256));
    exp_err  = !exp_done;
  endfunction

  task automatic push_bytes(input logic [127:0] v, input int cnt);
    stream_q.delete();
    for (int i = 0; i < cnt; i++) stream_q.push_back(v[8 * (cnt - 1 - i) +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
  endtask

  task automatic run_load(input string tag, input int max_gap, input bit stray);
    got_q.delete();
    done_cnt = 0; hold_at_done = 1'b0; hold_after_done = 1'b1; hold_dropped = 1'b0;
    flash_v = 1'b1;
    if (stray) begin
      rx_valid = 1'b1;
      rx_byte  = 8'hEE;
    end
    @(negedge clk);
    flash_v  = 1'b0;
    rx_valid = 1'b0;
    check_value({tag, ".edge_busy"}, busy_s, 64'd1);
    check_value({tag, ".edge_hold"}, hold_s, 64'd1);
    check_value({tag, ".edge_err"}, err_s, 64'd0);
    foreach (stream_q[i]) send_byte(stream_q[i], max_gap);
    for (int c = 0; c < 400 && busy_s; c++) @(negedge clk);
    @(negedge clk);
    #1;
    build_expect(sel ? 2 : 4, !sel);
    check_value({tag, ".busy_end"}, busy_s, 64'd0);
    check_value({tag, ".nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_value({tag, ".addr"}, got_q[i].addr, exp_q[i].addr);
      check_value({tag, ".data"}, got_q[i].data, exp_q[i].data);
    end
    check_value({tag, ".done"}, done_cnt, exp_done ? 64'd1 : 64'd0);
    check_value({tag, ".err"}, err_s, exp_err);
    check_value({tag, ".wc"}, wc_s, exp_wc);
    check_value({tag, ".hold_idle"}, hold_s, exp_err);
    check_value({tag, ".hold_drop"}, hold_dropped, 64'd0);
    if (exp_done) begin
      check_value({tag, ".hold_at_done"}, hold_at_done, 64'd1);
      check_value({tag, ".hold_after"}, hold_after_done, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int sum;
    logic [7:0] b;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    check_value("rst_a", {busy_a, hold_a, done_a, err_a, if_a.mem_we, wc_a, if_a.mem_addr, if_a.mem_wdata}, 64'd0);
    check_value("rst_b", {busy_b, hold_b, done_b, err_b, if_b.mem_we, wc_b, if_b.mem_addr, if_b.mem_wdata}, 64'd0);

    // Flash held high across reset release starts a load; async reset aborts it.
    flash_v = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_value("flash_at_reset_busy", busy_a, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_value("abort_busy", busy_a, 64'd0);
    check_value("abort_hold", hold_a, 64'd0);
    flash_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    push_bytes(128'h02001300000093001000B6, 11);
    run_load("normal", 2, 1'b1);
    check_value("normal.d0", got_q.size() > 0 ? got_q[0].data : 64'hDEAD, 64'h00000013);
    check_value("normal.d1", got_q.size() > 1 ? got_q[1].data : 64'hDEAD, 64'h00100093);

    sel = 1'b1;
    push_bytes(128'h0100ABCD78, 5);
    run_load("big_endian", 1, 1'b0);
    check_value("big_endian.d0", got_q.size() > 0 ? got_q[0].data : 64'hDEAD, 64'hABCD);

    sel = 1'b0;
    push_bytes(128'h02001300000093001000_00, 11);
    run_load("bad_csum", 1, 1'b0);
    push_bytes(128'h000000, 3);
    run_load("empty", 1, 1'b0);
    push_bytes(128'h0104, 2);
    run_load("oversize", 1, 1'b0);

    // Exactly full memory on the 16-bit instance: last write lands at address 1023.
    sel = 1'b1;
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h04);
    sum = 0;
    repeat (2048) begin
      b = 8'($urandom);
      sum += int'(b);
      stream_q.push_back(b);
    end
    stream_q.push_back(8'(sum));
    run_load("full", 0, 1'b0);
    check_value("full.last_addr", got_q.size() > 0 ? got_q[got_q.size() - 1].addr : 16'hFFFF, 64'd1023);

    for (int it = 0; it < 12; it++) begin
      int n;
      int bpw;
      sel = ($urandom_range(1, 0) == 1);
      bpw = sel ? 2 : 4;
      n   = $urandom_range(5, 0);
      stream_q.delete();
      stream_q.push_back(8'(n));
      stream_q.push_back(8'h00);
      sum = 0;
      repeat (n * bpw) begin
        b = 8'($urandom);
        sum += int'(b);
        stream_q.push_back(b);
      end
      if ($urandom_range(3, 0) == 0) sum += $urandom_range(255, 1);
      stream_q.push_back(8'(sum));
      run_load("random", 3, 1'b0);
    end

    // Timeout: silence after the last strobe; error must rise TMO clocks after it is sampled,
    // which is the (TMO+1)-th falling edge after the strobe was driven.
    sel = 1'b0;
    got_q.delete();
    flash_v = 1'b1;
    @(negedge clk);
    flash_v = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    rx_valid = 1'b1;
    rx_byte  = 8'h22;
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (err_a) break;
    end
    check_value("tmo.cycles", k, TMO + 1);
    check_value("tmo.nowr", got_q.size(), 64'd0);
    for (int c = 0; c < 10 && busy_a; c++) @(negedge clk);
    check_value("tmo.hold", {busy_a, hold_a}, 64'd1);

    // Reset in the middle of the payload, then stray bytes while idle.
    flash_v = 1'b1;
    @(negedge clk);
    flash_v = 1'b0;
    push_bytes(128'h0200A1A2A3A4A5, 7);
    foreach (stream_q[i]) send_byte(stream_q[i], 0);
    check_value("midrst.wc_before", wc_a, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_value("midrst.async", {busy_a, hold_a, if_a.mem_we, done_a, err_a, wc_a}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    repeat (6) send_byte(8'($urandom), 1);
    repeat (3) @(negedge clk);
    check_value("midrst.nowr", got_q.size(), 64'd0);
    check_value("midrst.idle", {busy_a, hold_a, err_a}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
